me_fullsearch_ctrl: RTL

- Parametrised full-search motion-estimation sequencer for the H.264 inter-prediction datapath.
- Loads the current macroblock into the current-pixel register (CPR).
- Streams the search window column-pass by column-pass into the search-pixel register (SPR).
- Tags every candidate SAD with its (x,y) position, and supports back-pressure (stall), abort and a done pulse.
- Sits between the window/macroblock memories and the SAD array plus best-match comparator.

---
 rtl/me_fullsearch_ctrl_pkg.sv | 23 ++
 rtl/me_fullsearch_ctrl_wrap_counter.sv | 34 +++
 rtl/me_fullsearch_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/me_fullsearch_ctrl_pkg.sv
// Shared types and helpers for the full-search motion-estimation sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package me_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_CUR,
    SCAN,
    DRAIN,
    DONE
  } me_state_t;

  // Datapath mux select: hold the registers or shift a new row in
  localparam logic [1:0] SEL_HOLD   = 2'd0;
  localparam logic [1:0] SEL_VSHIFT = 2'd1;

  // Candidate positions per axis for a given macroblock / window size
  function automatic int ncand(input int macro_dim, input int search_dim);
    return search_dim - macro_dim + 1;
  endfunction

endpackage

// File: rtl/me_fullsearch_ctrl_wrap_counter.sv
// Up-counter that wraps to zero after a terminal value, with a terminal flag.
// Latency: count updates one cycle after en/clr; the flag is combinational on the count.
// Backpressure: none; the count holds whenever en is low.
module me_wrap_counter #(
  parameter int W    = 4,
  parameter int TERM = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic         i_clr,
  output logic [W-1:0] o_count,
  output logic         o_tc
);

  logic [W-1:0] r_count;
  logic         w_tc;

  assign w_tc    = (r_count == W'(TERM));
  assign o_count = r_count;
  assign o_tc    = w_tc;

  // Clear has priority; otherwise step and wrap to zero on the terminal value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= w_tc ? '0 : r_count + W'(1);
    end
  end

endmodule

// File: rtl/me_fullsearch_ctrl.sv
// Full-search ME sequencer: loads the CPR, streams the window per column pass into the SPR, tags SADs.
// Latency: candidate tag one cycle after its completing shift; done two cycles after the last shift.
// Backpressure: stall freezes LOAD_CUR/SCAN (no enables, no new valid); abort returns to IDLE.
module me_fullsearch_ctrl
  import me_pkg::*;
#(
  parameter  int MACRO_DIM  = 16,
  parameter  int SEARCH_DIM = 48,
  localparam int NCAND      = ncand(MACRO_DIM, SEARCH_DIM),
  localparam int AW         = $clog2(SEARCH_DIM),
  localparam int CW         = $clog2(NCAND)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic          i_stall,
  output logic          o_ready,
  output logic          o_en_cpr,
  output logic          o_en_spr,
  output logic [1:0]    o_sel,
  output logic [AW-1:0] o_addr,
  output logic [CW-1:0] o_hoff,
  output logic          o_valid,
  output logic [CW-1:0] o_cand_x,
  output logic [CW-1:0] o_cand_y,
  output logic          o_done
);

  me_state_t     r_state, w_next;
  logic [AW-1:0] w_row;
  logic [CW-1:0] w_hoff;
  logic          w_row_tc, w_hoff_tc;
  logic          w_abort, w_step_cur, w_step_scan, w_cur_last;
  logic          w_row_en, w_row_clr, w_hoff_en, w_hoff_clr, w_cand_done;
  logic          r_valid;
  logic [CW-1:0] r_cand_x, r_cand_y;

  // A step is a cycle that actually moves a row; abort and stall both suppress it
  assign w_abort     = i_abort && (r_state != IDLE);
  assign w_step_cur  = (r_state == LOAD_CUR) && !i_abort && !i_stall;
  assign w_step_scan = (r_state == SCAN) && !i_abort && !i_stall;
  assign w_cur_last  = (w_row == AW'(MACRO_DIM - 1));

  // The row counter wraps at the window height; the shorter CPR load ends by clearing it
  assign w_row_en    = w_step_cur || w_step_scan;
  assign w_row_clr   = w_abort || (r_state == IDLE) || (w_step_cur && w_cur_last);
  assign w_hoff_en   = w_step_scan && w_row_tc;
  assign w_hoff_clr  = w_abort || (r_state == IDLE);

  // Once MACRO_DIM rows of a pass are in the SPR, every further shift completes a candidate
  assign w_cand_done = w_step_scan && (w_row >= AW'(MACRO_DIM - 1));

  me_wrap_counter #(.W(AW), .TERM(SEARCH_DIM - 1)) u_row (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_row_en),
    .i_clr   (w_row_clr),
    .o_count (w_row),
    .o_tc    (w_row_tc)
  );

  me_wrap_counter #(.W(CW), .TERM(NCAND - 1)) u_hoff (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_hoff_en),
    .i_clr   (w_hoff_clr),
    .o_count (w_hoff),
    .o_tc    (w_hoff_tc)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and row-write enables; stall and abort drop the enables to hold
  always_comb begin
    w_next   = r_state;
    o_en_cpr = 1'b0;
    o_en_spr = 1'b0;
    o_sel    = SEL_HOLD;
    case (r_state)
      IDLE: begin
        if (i_start) w_next = LOAD_CUR;
      end
      LOAD_CUR: begin
        if (i_abort) begin
          w_next = IDLE;
        end else if (!i_stall) begin
          o_en_cpr = 1'b1;
          o_sel    = SEL_VSHIFT;
          if (w_cur_last) w_next = SCAN;
        end
      end
      SCAN: begin
        if (i_abort) begin
          w_next = IDLE;
        end else if (!i_stall) begin
          o_en_spr = 1'b1;
          o_sel    = SEL_VSHIFT;
          if (w_row_tc && w_hoff_tc) w_next = DRAIN;
        end
      end
      DRAIN: begin
        w_next = i_abort ? IDLE : DONE;
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Candidate tag lines up with the SAD array's registered SPR, one cycle after the shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_cand_x <= '0;
      r_cand_y <= '0;
    end else begin
      r_valid <= w_cand_done;
      if (w_cand_done) begin
        r_cand_x <= w_hoff;
        r_cand_y <= CW'(w_row - AW'(MACRO_DIM - 1));
      end
    end
  end

  assign o_ready  = (r_state == IDLE);
  assign o_done   = (r_state == DONE);
  assign o_addr   = w_row;
  assign o_hoff   = w_hoff;
  assign o_valid  = r_valid;
  assign o_cand_x = r_cand_x;
  assign o_cand_y = r_cand_y;

endmodule
